// File: rtl/ext_reg_arbiter.sv
// ext_reg_arbiter
// Round-robin arbiter sharing one external-register port between N_REQ
// requesters. One transaction is outstanding at a time. A watchdog turns a
// missing device acknowledge into an error response after TIMEOUT cycles.
//
// Ports
//   clk, arst_n       clock, asynchronous active-low reset
//   up_req/up_is_wr   per-requester request level and direction
//   up_strb           per-requester subword select, slice i at [i*SUBWORDS +: SUBWORDS]
//   up_wr_data/biten  per-requester write data and bit enables
//   up_ack/up_err     one-cycle completion pulse / timeout flag to the grantee
//   up_rd_data        read data, valid only in the up_ack cycle
//   req/req_is_wr     downstream strobe (one cycle) and direction
//   wr_data/wr_biten  downstream write data and bit enables
//   rd_ack/rd_data    downstream read acknowledge and data
//   wr_ack            downstream write acknowledge
module ext_reg_arbiter #(
    parameter int WIDTH    = 32,
    parameter int SUBWORDS = 1,
    parameter int N_REQ    = 2,
    parameter int TIMEOUT  = 15
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic [N_REQ-1:0]             up_req,
    input  logic [N_REQ-1:0]             up_is_wr,
    input  logic [N_REQ*SUBWORDS-1:0]    up_strb,
    input  logic [N_REQ*WIDTH-1:0]       up_wr_data,
    input  logic [N_REQ*WIDTH-1:0]       up_wr_biten,
    output logic [N_REQ-1:0]             up_ack,
    output logic [N_REQ-1:0]             up_err,
    output logic [WIDTH-1:0]             up_rd_data,
    output logic [SUBWORDS-1:0]          req,
    output logic                         req_is_wr,
    output logic [WIDTH-1:0]             wr_data,
    output logic [WIDTH-1:0]             wr_biten,
    input  logic                         rd_ack,
    input  logic [WIDTH-1:0]             rd_data,
    input  logic                         wr_ack
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q;
    logic [PW-1:0]       ptr_q, grant_q;
    logic [CW-1:0]       cnt_q;
    logic [SUBWORDS-1:0] req_q;
    logic                req_is_wr_q;
    logic [WIDTH-1:0]    wr_data_q, wr_biten_q, up_rd_data_q;
    logic [N_REQ-1:0]    up_ack_q, up_err_q;

    logic                pick_vld_d;
    logic [PW-1:0]       pick_d, ptr_d;
    logic                sel_wr_d;
    logic [SUBWORDS-1:0] sel_strb_d;
    logic [WIDTH-1:0]    sel_data_d, sel_biten_d;
    logic [N_REQ-1:0]    grant_oh;
    logic                exp_ack;

    // Rotating priority without a modulo: the first pass only considers
    // requesters at or above the pointer; if none is found the second pass
    // takes the lowest index, which is the wrapped-around candidate.
    always_comb begin
        pick_vld_d = 1'b0;
        pick_d     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!pick_vld_d && up_req[k] && (PW'(k) >= ptr_q)) begin
                pick_vld_d = 1'b1;
                pick_d     = PW'(k);
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (!pick_vld_d && up_req[k]) begin
                pick_vld_d = 1'b1;
                pick_d     = PW'(k);
            end
        end
    end

    // Payload mux for the candidate grantee.
    always_comb begin
        sel_wr_d    = 1'b0;
        sel_strb_d  = '0;
        sel_data_d  = '0;
        sel_biten_d = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (PW'(k) == pick_d) begin
                sel_wr_d    = up_is_wr[k];
                sel_strb_d  = up_strb[k*SUBWORDS +: SUBWORDS];
                sel_data_d  = up_wr_data[k*WIDTH +: WIDTH];
                sel_biten_d = up_wr_biten[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        grant_oh          = '0;
        grant_oh[grant_q] = 1'b1;
    end

    assign ptr_d   = (grant_q == PW'(N_REQ - 1)) ? '0 : grant_q + PW'(1);
    // Only the ack matching the latched direction completes the transaction.
    assign exp_ack = req_is_wr_q ? wr_ack : rd_ack;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            grant_q      <= '0;
            cnt_q        <= '0;
            req_q        <= '0;
            req_is_wr_q  <= 1'b0;
            wr_data_q    <= '0;
            wr_biten_q   <= '0;
            up_ack_q     <= '0;
            up_err_q     <= '0;
            up_rd_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld_d) begin
                        grant_q     <= pick_d;
                        req_q       <= sel_strb_d;
                        req_is_wr_q <= sel_wr_d;
                        wr_data_q   <= sel_data_d;
                        wr_biten_q  <= sel_biten_d;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    req_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (exp_ack) begin
                        up_ack_q     <= grant_oh;
                        up_err_q     <= '0;
                        up_rd_data_q <= req_is_wr_q ? '0 : rd_data;
                        state_q      <= RESP;
                    end else if (cnt_q == CW'(TIMEOUT)) begin
                        up_ack_q     <= grant_oh;
                        up_err_q     <= grant_oh;
                        up_rd_data_q <= '0;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    up_ack_q     <= '0;
                    up_err_q     <= '0;
                    up_rd_data_q <= '0;
                    ptr_q        <= ptr_d;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign up_ack     = up_ack_q;
    assign up_err     = up_err_q;
    assign up_rd_data = up_rd_data_q;
    assign req        = req_q;
    assign req_is_wr  = req_is_wr_q;
    assign wr_data    = wr_data_q;
    assign wr_biten   = wr_biten_q;

endmodule
